fetch_stage: RTL

- Instruction-fetch stage; it is the producer side of the decode interface.
- Owns the PC and issues requests to a variable-latency instruction memory over a req/ready, rvalid handshake.
- Drives the IF/ID register that feeds decode: instrD, pc_plus_4_decoded, validD.
- Consumes decode's redirect outputs (branch taken plus target, jump plus target, jr plus target) and the hazard unit's stalls.

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/fetch_stage_next_pc_sel.sv | 39 +++
 rtl/fetch_stage.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction-fetch stage:
//                fetch FSM state encoding, reset PC, bubble instruction word
//                and a saturating-increment helper for the statistics counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  // Fetch FSM states. ISSUE is the only state that drives a request.
  typedef enum logic [1:0] {
    ISSUE  = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2,
    SQUASH = 2'd3
  } fetch_state_e;

  // Text segment base loaded into the PC on reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  // sll $0,$0,0 : the word shown to decode when IF/ID carries a bubble.
  localparam logic [31:0] NOP_INSTR_WORD = 32'h0000_0000;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/fetch_stage_next_pc_sel.sv
// ============================================================================
//  Module      : next_pc_sel
//  Description : Combinational redirect detection and target selection for
//                the fetch stage. A redirect from decode is only honoured when
//                the IF/ID register is not stalled; the target priority is
//                jr > jump > branch. Target low bits pass through untouched.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module next_pc_sel
  import fetch_pkg::*;
(
  input  logic        stall_d_i,
  input  logic        pcsrc_d_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_d_i,
  input  logic [31:0] jump_target_i,
  input  logic        jr_d_i,
  input  logic [31:0] jr_target_i,
  output logic        redirect_o,
  output logic [31:0] target_o
);

  // Decode keeps presenting a redirect across a stall, so a stalled
  // redirect is simply ignored here and picked up once the stall clears.
  always_comb begin
    redirect_o = (jr_d_i | jump_d_i | pcsrc_d_i) & ~stall_d_i;
    target_o   = branch_target_i;
    if (jr_d_i) begin
      target_o = jr_target_i;
    end else if (jump_d_i) begin
      target_o = jump_target_i;
    end
  end

endmodule : next_pc_sel

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage. Owns the PC, issues single
//                outstanding requests to a variable-latency instruction
//                memory (req/ready, rvalid), buffers a response that arrives
//                while fetch is stalled, squashes responses made stale by a
//                redirect and drives the IF/ID register feeding decode.
//                Optional macro FETCH_STATS_EN adds saturating counters
//                stat_fetched and stat_squashed.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        pcsrcD,
  input  logic [31:0] branch_target,
  input  logic        jumpD,
  input  logic [31:0] jump_target,
  input  logic        jrD,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pc_plus_4_decoded,
  output logic        validD
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_squashed
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  ppc4_q, ppc4_d;
  logic         valid_q, valid_d;

  logic         redirect;
  logic [31:0]  target;
  logic         req;
  logic         deliver;
  logic [31:0]  deliver_word;
  logic         squash_evt;
  logic [31:0]  pc_plus_4;

  next_pc_sel u_next_pc_sel (
    .stall_d_i       (stallD),
    .pcsrc_d_i       (pcsrcD),
    .branch_target_i (branch_target),
    .jump_d_i        (jumpD),
    .jump_target_i   (jump_target),
    .jr_d_i          (jrD),
    .jr_target_i     (jr_target),
    .redirect_o      (redirect),
    .target_o        (target)
  );

  // Wraps modulo 2^32 by construction.
  assign pc_plus_4 = pc_q + 32'd4;

  // Next-state logic: one outstanding request, redirects and fetch stalls.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_d       = hold_q;
    req          = 1'b0;
    deliver      = 1'b0;
    deliver_word = hold_q;
    squash_evt   = 1'b0;
    case (state_q)
      ISSUE: begin
        req = 1'b1;
        // Until the request is accepted the address may still move.
        if (redirect) begin
          pc_d = target;
        end
        if (imem_ready) begin
          state_d = redirect ? SQUASH : WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (redirect) begin
            squash_evt = 1'b1;
            pc_d       = target;
            state_d    = ISSUE;
          end else if (!stallF) begin
            deliver      = 1'b1;
            deliver_word = imem_rdata;
            pc_d         = pc_plus_4;
            state_d      = ISSUE;
          end else begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end
        end else if (redirect) begin
          // Response still in flight: it must be thrown away on arrival.
          pc_d    = target;
          state_d = SQUASH;
        end
      end
      HOLD: begin
        if (redirect) begin
          squash_evt = 1'b1;
          pc_d       = target;
          state_d    = ISSUE;
        end else if (!stallF) begin
          deliver      = 1'b1;
          deliver_word = hold_q;
          pc_d         = pc_plus_4;
          state_d      = ISSUE;
        end
      end
      SQUASH: begin
        // A further redirect only retargets the PC; the stale response is
        // still owed and must be drained before issuing again.
        if (redirect) begin
          pc_d = target;
        end
        if (imem_rvalid) begin
          squash_evt = 1'b1;
          state_d    = ISSUE;
        end
      end
      default: begin
        state_d = ISSUE;
      end
    endcase
  end

  // IF/ID next value: hold on stallD, otherwise instruction or bubble.
  always_comb begin
    instr_d = instr_q;
    ppc4_d  = ppc4_q;
    valid_d = valid_q;
    if (!stallD) begin
      if (deliver) begin
        instr_d = deliver_word;
        ppc4_d  = pc_plus_4;
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  // State, PC, hold buffer and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ISSUE;
      pc_q    <= RESET_PC;
      hold_q  <= 32'h0;
      instr_q <= NOP_INSTR;
      ppc4_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      ppc4_q  <= ppc4_d;
      valid_q <= valid_d;
    end
  end

  // The request is suppressed during the reset cycle itself.
  assign imem_req          = req & ~rst;
  assign imem_addr         = pc_q;
  assign instrD            = instr_q;
  assign pc_plus_4_decoded = ppc4_q;
  assign validD            = valid_q;

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_q;
  logic [31:0] squashed_q;

  // Saturating counters of delivered and discarded instructions.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q  <= 32'h0;
      squashed_q <= 32'h0;
    end else begin
      if (deliver && !stallD) begin
        fetched_q <= sat_inc(fetched_q);
      end
      if (squash_evt) begin
        squashed_q <= sat_inc(squashed_q);
      end
    end
  end

  assign stat_fetched  = fetched_q;
  assign stat_squashed = squashed_q;
`endif

endmodule : fetch_stage

`default_nettype wire
